decode_execute_unit: RTL and testbench

- Combined main control decoder, ALU control decoder and 32-bit ALU for the 5-stage MIPS-subset pipeline.
- Decodes the instruction and generates the pipeline control signals.
- Selects the ALU B operand, computes the ALU result and zero flag, and registers everything into one output stage (1-cycle latency).
- Sits between the IF/ID register and the EX/MEM path.

---
 rtl/decode_execute_unit.sv | 166 ++++++++++++++++
 tb/tb_decode_execute_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/decode_execute_unit.sv
// Main decoder, ALU control decoder and 32-bit ALU for the MIPS-subset pipeline,
// with every result captured in one output register stage (1-cycle latency).
module decode_execute_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        noop,
  output logic        reg_dst,
  output logic        branch,
  output logic        branch_n,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        jump,
  output logic        alu_src,
  output logic        reg_write,
  output logic        ld_pc,
  output logic [1:0]  alu_op,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero
);

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       branch_n;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       jump;
    logic       alu_src;
    logic       reg_write;
    logic       ld_pc;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_sx;
  logic        w_unused;
  ctrl_t       w_ctrl;
  ctrl_t       w_ctrl_masked;
  logic [31:0] w_b;
  logic [31:0] w_result;

  ctrl_t       r_ctrl;
  logic [31:0] r_result;
  logic        r_zero;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_imm_sx = {{16{instr[15]}}, instr[15:0]};
  assign w_unused = ^instr[25:16];

  always_comb begin
    w_ctrl       = '0;
    w_ctrl.ld_pc = 1'b1;
    case (w_opcode)
      6'b000000: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = 2'b10;
      end
      6'b100011: begin
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
      end
      6'b101011: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      6'b000100: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = 2'b01;
      end
      6'b000101: begin
        w_ctrl.branch_n = 1'b1;
        w_ctrl.alu_op   = 2'b01;
      end
      6'b000010: w_ctrl.jump = 1'b1;
      6'b001000: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      6'b001010: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = 2'b11;
      end
      default: ;
    endcase

    case (w_ctrl.alu_op)
      2'b01:   w_ctrl.alu_ctrl = ALU_SUB;
      2'b11:   w_ctrl.alu_ctrl = ALU_SLT;
      2'b10: begin
        case (w_funct)
          6'b100010: w_ctrl.alu_ctrl = ALU_SUB;
          6'b100100: w_ctrl.alu_ctrl = ALU_AND;
          6'b100101: w_ctrl.alu_ctrl = ALU_OR;
          6'b100111: w_ctrl.alu_ctrl = ALU_NOR;
          6'b101010: w_ctrl.alu_ctrl = ALU_SLT;
          default:   w_ctrl.alu_ctrl = ALU_ADD;
        endcase
      end
      default: w_ctrl.alu_ctrl = ALU_ADD;
    endcase
  end

  // The bubble masks only the control word; the ALU still runs on the real decode.
  assign w_ctrl_masked = noop ? ctrl_t'('0) : w_ctrl;
  assign w_b           = w_ctrl.alu_src ? w_imm_sx : rt_data;

  always_comb begin
    w_result = rs_data + w_b;
    case (w_ctrl.alu_ctrl)
      ALU_AND: w_result = rs_data & w_b;
      ALU_OR:  w_result = rs_data | w_b;
      ALU_NOR: w_result = ~(rs_data | w_b);
      ALU_SUB: w_result = rs_data - w_b;
      ALU_SLT: w_result = ($signed(rs_data) < $signed(w_b)) ? 32'd1 : 32'd0;
      default: w_result = rs_data + w_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_ctrl   <= w_ctrl_masked;
      r_result <= w_result;
      r_zero   <= (w_result == 32'd0);
    end
  end

  assign reg_dst    = r_ctrl.reg_dst;
  assign branch     = r_ctrl.branch;
  assign branch_n   = r_ctrl.branch_n;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign jump       = r_ctrl.jump;
  assign alu_src    = r_ctrl.alu_src;
  assign reg_write  = r_ctrl.reg_write;
  assign ld_pc      = r_ctrl.ld_pc;
  assign alu_op     = r_ctrl.alu_op;
  assign alu_ctrl   = r_ctrl.alu_ctrl;
  assign alu_result = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed bench for decode_execute_unit: expected output words are queued when
// stimulus is applied and popped/compared one cycle later.
module tb_decode_execute_unit;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        noop;
  logic        reg_dst, branch, branch_n, mem_read, mem_write, mem_to_reg;
  logic        jump, alu_src, reg_write, ld_pc;
  logic [1:0]  alu_op;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;

  int n_cmp;
  int n_fail;
  logic [47:0] exp_q[$];

  // control bit order: reg_dst branch branch_n mem_read mem_write mem_to_reg jump alu_src reg_write ld_pc
  localparam logic [9:0] C_R    = 10'b1000000011;
  localparam logic [9:0] C_LW   = 10'b0001010111;
  localparam logic [9:0] C_SW   = 10'b0000100101;
  localparam logic [9:0] C_BEQ  = 10'b0100000001;
  localparam logic [9:0] C_BNE  = 10'b0010000001;
  localparam logic [9:0] C_J    = 10'b0000001001;
  localparam logic [9:0] C_IMM  = 10'b0000000111;
  localparam logic [9:0] C_UNK  = 10'b0000000001;
  localparam logic [9:0] C_NONE = 10'b0000000000;

  decode_execute_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .noop(noop),
    .reg_dst(reg_dst), .branch(branch), .branch_n(branch_n), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .jump(jump), .alu_src(alu_src),
    .reg_write(reg_write), .ld_pc(ld_pc), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  function automatic logic [47:0] observed();
    return {reg_dst, branch, branch_n, mem_read, mem_write, mem_to_reg, jump, alu_src,
            reg_write, ld_pc, alu_op, alu_ctrl, alu_result, zero};
  endfunction

  function automatic logic [47:0] mk(input logic [9:0] c, input logic [1:0] op,
                                     input logic [2:0] ac, input logic [31:0] res);
    return {c, op, ac, res, (res == 32'd0)};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b, input logic n, input logic [47:0] expv);
    logic [47:0] e;
    @(negedge clk);
    instr   = i;
    rs_data = a;
    rt_data = b;
    noop    = n;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, observed(), e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    rst     = 1'b1;
    instr   = itype(6'b100011, 16'h1234);
    rs_data = 32'hDEADBEEF;
    rt_data = 32'h12345678;
    noop    = 1'b0;
    #3;
    check("reset_no_clock", observed(), 48'd0);

    // reset has priority over noop and over a live clock
    clk_en = 1'b1;
    noop   = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held_clocked", observed(), 48'd0);
    @(negedge clk);
    rst  = 1'b0;
    noop = 1'b0;

    step("r_add",     rtype(6'b100000), 32'd5,  32'd7,  1'b0, mk(C_R, 2'b10, 3'b010, 32'd12));
    step("r_sub",     rtype(6'b100010), 32'hC,  32'hA,  1'b0, mk(C_R, 2'b10, 3'b110, 32'd2));
    step("r_and",     rtype(6'b100100), 32'hC,  32'hA,  1'b0, mk(C_R, 2'b10, 3'b000, 32'd8));
    step("r_or",      rtype(6'b100101), 32'hC,  32'hA,  1'b0, mk(C_R, 2'b10, 3'b001, 32'd14));
    step("r_nor",     rtype(6'b100111), 32'hC,  32'hA,  1'b0, mk(C_R, 2'b10, 3'b011, 32'hFFFFFFF1));
    step("r_slt",     rtype(6'b101010), 32'hC,  32'hA,  1'b0, mk(C_R, 2'b10, 3'b111, 32'd0));
    step("r_slt_neg", rtype(6'b101010), 32'hFFFFFFFE, 32'd3, 1'b0, mk(C_R, 2'b10, 3'b111, 32'd1));
    step("r_funct0",  rtype(6'b000000), 32'hC,  32'hA,  1'b0, mk(C_R, 2'b10, 3'b010, 32'd22));
    step("r_funct21", rtype(6'b100001), 32'hC,  32'hA,  1'b0, mk(C_R, 2'b10, 3'b010, 32'd22));

    step("lw",   itype(6'b100011, 16'hFFFC), 32'h100, 32'h1234, 1'b0, mk(C_LW, 2'b00, 3'b010, 32'hFC));
    step("sw",   itype(6'b101011, 16'hFFFC), 32'h100, 32'h1234, 1'b0, mk(C_SW, 2'b00, 3'b010, 32'hFC));
    step("beq",  itype(6'b000100, 16'h0010), 32'h55,  32'h55,   1'b0, mk(C_BEQ, 2'b01, 3'b110, 32'd0));
    step("bne",  itype(6'b000101, 16'h0010), 32'd1,   32'd2,    1'b0, mk(C_BNE, 2'b01, 3'b110, 32'hFFFFFFFF));
    step("slti_t", itype(6'b001010, 16'h0001), 32'hFFFFFFFF, 32'd0, 1'b0, mk(C_IMM, 2'b11, 3'b111, 32'd1));
    step("slti_f", itype(6'b001010, 16'hFFFF), 32'd5,        32'd0, 1'b0, mk(C_IMM, 2'b11, 3'b111, 32'd0));
    step("addi_wrap", itype(6'b001000, 16'h0001), 32'h7FFFFFFF, 32'd9, 1'b0, mk(C_IMM, 2'b00, 3'b010, 32'h80000000));
    step("jump", {6'b000010, 26'h0ABCDEF}, 32'd3, 32'd4, 1'b0, mk(C_J, 2'b00, 3'b010, 32'd7));
    step("unknown", itype(6'b111111, 16'h8000), 32'd10, 32'd20, 1'b0, mk(C_UNK, 2'b00, 3'b010, 32'd30));

    step("noop_lw",  itype(6'b100011, 16'hFFFC), 32'h100, 32'h1234, 1'b1, mk(C_NONE, 2'b00, 3'b000, 32'hFC));
    step("noop_beq", itype(6'b000100, 16'h0000), 32'h77,  32'h77,   1'b1, mk(C_NONE, 2'b00, 3'b000, 32'd0));
    step("after_noop", rtype(6'b100010), 32'd1, 32'd9, 1'b0, mk(C_R, 2'b10, 3'b110, 32'hFFFFFFF8));

    // asynchronous clear between edges
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_cycle", observed(), 48'd0);
    @(negedge clk);
    rst = 1'b0;

    step("post_reset_lw", itype(6'b100011, 16'h0004), 32'h20, 32'd0, 1'b0, mk(C_LW, 2'b00, 3'b010, 32'h24));

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
